// File: rtl/fifo_drain_ctrl.sv
// Read-side drain controller for scfifo sample buffers: drains in bursts between watermarks; read is combinational (first read the cycle after the trigger), stalls on !sink_ready_i.
// Optional DRAIN_STATS_EN adds wrapping words_read_o / drain_events_o counters.
module fifo_drain_ctrl #(
  parameter int DEPTH_W    = 10,
  parameter int HIGH_MARK  = 768,
  parameter int LOW_MARK   = 256,
  parameter int BURST_LEN  = 16,
  parameter int GAP_CYCLES = 4,
  parameter int ONESHOT    = 0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic               full_i,
  input  logic               empty_i,
  input  logic [DEPTH_W-1:0] usedw_i,
  input  logic               sink_ready_i,
  output logic               read_o,
  output logic               draining_o,
  output logic               burst_done_o,
  output logic               full_seen_o
`ifdef DRAIN_STATS_EN
  ,
  output logic [31:0]        words_read_o,
  output logic [15:0]        drain_events_o
`endif
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BCW-1:0] BURST_LAST = BCW'((BURST_LEN > 0) ? BURST_LEN - 1 : 0);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [DEPTH_W-1:0] HIGH_LVL = DEPTH_W'(HIGH_MARK);
  localparam logic [DEPTH_W-1:0] LOW_LVL  = DEPTH_W'(LOW_MARK);
  localparam bit BURSTED = (BURST_LEN > 0);
  localparam bit ONE     = (ONESHOT != 0);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_GAP} state_e;

  state_e           state_q;
  logic [BCW-1:0]   burst_cnt_q;
  logic [GCW-1:0]   gap_cnt_q;
  logic             full_seen_q;
  logic             burst_done_q;

  logic above_low;
  logic exit_cond;
  logic start_drain;

  assign above_low   = (usedw_i > LOW_LVL);
  assign exit_cond   = !ONE && (empty_i || !above_low);
  assign start_drain = (state_q == ST_IDLE) && enable_i && (full_i || (usedw_i >= HIGH_LVL));

  // Gated by the registered state, so an async reset kills read immediately.
  assign read_o       = (state_q == ST_DRAIN) && !empty_i && sink_ready_i && (ONE || above_low);
  assign draining_o   = (state_q != ST_IDLE);
  assign burst_done_o = burst_done_q;
  assign full_seen_o  = full_seen_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      full_seen_q  <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      if (clear_i) begin
        state_q     <= ST_IDLE;
        burst_cnt_q <= '0;
        gap_cnt_q   <= '0;
        full_seen_q <= 1'b0;
      end else begin
        if (full_i) full_seen_q <= 1'b1;
        if (!enable_i) begin
          state_q <= ST_IDLE;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (start_drain) begin
                state_q     <= ST_DRAIN;
                burst_cnt_q <= '0;
              end
            end
            ST_DRAIN: begin
              if (read_o) begin
                // Burst end takes precedence; the level exit is re-evaluated after the gap.
                if (BURSTED && (burst_cnt_q == BURST_LAST)) begin
                  burst_done_q <= 1'b1;
                  burst_cnt_q  <= '0;
                  gap_cnt_q    <= GAP_LAST;
                  state_q      <= ST_GAP;
                end else begin
                  burst_cnt_q <= burst_cnt_q + 1'b1;
                end
              end else if (exit_cond) begin
                state_q <= ST_IDLE;
              end
            end
            ST_GAP: begin
              if (gap_cnt_q == '0) begin
                state_q <= exit_cond ? ST_IDLE : ST_DRAIN;
              end else begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

`ifdef DRAIN_STATS_EN
  logic [31:0] words_read_q, words_read_d;
  logic [15:0] drain_events_q, drain_events_d;

  always_comb begin
    words_read_d   = words_read_q + {31'd0, read_o};
    drain_events_d = drain_events_q + {15'd0, start_drain};
    if (clear_i) begin
      words_read_d   = '0;
      drain_events_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      words_read_q   <= '0;
      drain_events_q <= '0;
    end else begin
      words_read_q   <= words_read_d;
      drain_events_q <= drain_events_d;
    end
  end

  assign words_read_o   = words_read_q;
  assign drain_events_o = drain_events_q;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench: three controllers (default, one-shot, unlimited burst) each fed by a registered FIFO level model.
module tb_fifo_drain_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       en[3], clr[3], srdy[3], wr[3], ld[3];
  int         ld_val[3];
  int         lvl[3];
  logic [9:0] usedw[3];
  logic       full[3], empty[3];
  logic       rd[3], drn[3], bdone[3], fseen[3];
`ifdef DRAIN_STATS_EN
  logic [31:0] wrd[3];
  logic [15:0] dev[3];
`endif

  int n_vec = 0;
  int n_err = 0;

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign usedw[g] = lvl[g][9:0];
    assign full[g]  = (lvl[g] >= 1023);
    assign empty[g] = (lvl[g] == 0);
  end

  // Registered fill level: a read or write shows up in usedw on the following edge.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ld[i]) lvl[i] <= ld_val[i];
      else       lvl[i] <= lvl[i] + (wr[i] ? 1 : 0) - (rd[i] ? 1 : 0);
    end
  end

  fifo_drain_ctrl u_dflt (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en[0]), .clear_i(clr[0]),
    .full_i(full[0]), .empty_i(empty[0]), .usedw_i(usedw[0]), .sink_ready_i(srdy[0]),
    .read_o(rd[0]), .draining_o(drn[0]), .burst_done_o(bdone[0]), .full_seen_o(fseen[0])
`ifdef DRAIN_STATS_EN
    , .words_read_o(wrd[0]), .drain_events_o(dev[0])
`endif
  );

  fifo_drain_ctrl #(.ONESHOT(1)) u_once (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en[1]), .clear_i(clr[1]),
    .full_i(full[1]), .empty_i(empty[1]), .usedw_i(usedw[1]), .sink_ready_i(srdy[1]),
    .read_o(rd[1]), .draining_o(drn[1]), .burst_done_o(bdone[1]), .full_seen_o(fseen[1])
`ifdef DRAIN_STATS_EN
    , .words_read_o(wrd[1]), .drain_events_o(dev[1])
`endif
  );

  fifo_drain_ctrl #(.BURST_LEN(0)) u_unl (
    .clk_i(clk), .reset_n_i(rst_n), .enable_i(en[2]), .clear_i(clr[2]),
    .full_i(full[2]), .empty_i(empty[2]), .usedw_i(usedw[2]), .sink_ready_i(srdy[2]),
    .read_o(rd[2]), .draining_o(drn[2]), .burst_done_o(bdone[2]), .full_seen_o(fseen[2])
`ifdef DRAIN_STATS_EN
    , .words_read_o(wrd[2]), .drain_events_o(dev[2])
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int i, input int v);
    @(negedge clk);
    ld[i] = 1'b1;
    ld_val[i] = v;
    @(negedge clk);
    ld[i] = 1'b0;
  endtask

  // Ramp instance 0 to 768 then drain back to 256 in 16-read bursts with 4-cycle gaps.
  task automatic run_watermark(input string tag);
    int reads, bursts, gaps, badb, badramp;
    bit to;
    reads = 0; bursts = 0; gaps = 0; badb = 0; badramp = 0;
    en[0] = 1'b1;
    srdy[0] = 1'b1;
    to = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      @(negedge clk);
      if (lvl[0] < 768) begin
        wr[0] = 1'b1;
      end else begin
        wr[0] = 1'b0;
        to = 1'b0;
        break;
      end
      #1;
      if (drn[0] || rd[0]) badramp++;
    end
    #1;
    chk({tag, " ramp timeout"}, int'(to), 0);
    chk({tag, " ramp early drain"}, badramp, 0);
    chk({tag, " draining at usedw=768"}, int'(drn[0]), 0);
    @(negedge clk); #1;
    chk({tag, " draining next cycle"}, int'(drn[0]), 1);
    to = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (!drn[0]) begin
        to = 1'b0;
        break;
      end
      if (rd[0]) reads++;
      if (bdone[0]) begin
        bursts++;
        if (reads % 16 != 0) badb++;
      end
      if (!rd[0]) gaps++;
      @(negedge clk); #1;
    end
    chk({tag, " drain timeout"}, int'(to), 0);
    chk({tag, " total reads"}, reads, 512);
    chk({tag, " burst_done pulses"}, bursts, 32);
    chk({tag, " gap cycles"}, gaps, 128);
    chk({tag, " burst_done alignment"}, badb, 0);
    chk({tag, " final usedw"}, lvl[0], 256);
  endtask

  initial begin
    int reads, bad, done_c, stalls, bursts;
    bit found, to;
    logic [3:0] pat;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; clr[i] = 1'b0; srdy[i] = 1'b0;
      wr[i] = 1'b0; ld[i] = 1'b0; ld_val[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset read", int'(rd[0]), 0);
    chk("reset draining", int'(drn[0]), 0);
    chk("reset burst_done", int'(bdone[0]), 0);
    chk("reset full_seen", int'(fseen[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_watermark("wm1");
    run_watermark("wm2");
`ifdef DRAIN_STATS_EN
    chk("stats drain_events", int'(dev[0]), 2);
    chk("stats words_read", int'(wrd[0]), 1024);
`endif

    // Back-pressure: sink_ready 1,0,0,1 repeating from the first DRAIN cycle.
    pat = 4'b1001;
    load(0, 800);
    reads = 0; bad = 0; done_c = -1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      srdy[0] = pat[2'(c % 4)];
      #1;
      if (bdone[0]) begin
        done_c = c;
        break;
      end
      if (rd[0]) reads++;
      if (rd[0] !== srdy[0]) bad++;
    end
    chk("bp burst_done cycle", done_c, 32);
    chk("bp reads in burst", reads, 16);
    chk("bp read follows ready", bad, 0);

    srdy[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (rd[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("gap then drain resumes", int'(found), 1);
    @(negedge clk);
    en[0] = 1'b0;
    #1;
    @(negedge clk); #1;
    chk("enable low draining", int'(drn[0]), 0);
    chk("enable low read", int'(rd[0]), 0);

    // full_seen set, clear wins over simultaneous full, then re-sets.
    chk("full_seen before full", int'(fseen[0]), 0);
    load(0, 1023);
    #1;
    chk("full_seen same cycle", int'(fseen[0]), 0);
    @(negedge clk); #1;
    chk("full_seen set", int'(fseen[0]), 1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    #1;
    chk("full_seen clear wins", int'(fseen[0]), 0);
    @(negedge clk); #1;
    chk("full_seen re-set", int'(fseen[0]), 1);
    load(0, 500);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    #1;
    chk("full_seen cleared", int'(fseen[0]), 0);

    // Async reset mid-burst, then a fresh 16-read burst.
    en[0] = 1'b1;
    srdy[0] = 1'b1;
    load(0, 800);
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (rd[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst test drain start", int'(found), 1);
    repeat (3) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async reset read", int'(rd[0]), 0);
    chk("async reset draining", int'(drn[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    reads = 0; to = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (bdone[0]) begin
        to = 1'b0;
        break;
      end
      if (rd[0]) reads++;
    end
    chk("post-reset burst timeout", int'(to), 0);
    chk("post-reset burst reads", reads, 16);
    en[0] = 1'b0;

    // One-shot: full trigger, drains past LOW_MARK to empty and stays in DRAIN.
    en[1] = 1'b1;
    srdy[1] = 1'b1;
    load(1, 1023);
    reads = 0; to = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk); #1;
      if (rd[1]) reads++;
      if (lvl[1] == 0 && !rd[1]) begin
        to = 1'b0;
        break;
      end
    end
    chk("oneshot timeout", int'(to), 0);
    chk("oneshot reads to empty", reads, 1023);
    chk("oneshot full_seen", int'(fseen[1]), 1);
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rd[1] || !drn[1]) bad++;
    end
    chk("oneshot held while empty", bad, 0);
    @(negedge clk);
    clr[1] = 1'b1;
    @(negedge clk);
    clr[1] = 1'b0;
    #1;
    chk("oneshot draining after clear", int'(drn[1]), 0);
    chk("oneshot full_seen after clear", int'(fseen[1]), 0);
`ifdef DRAIN_STATS_EN
    chk("oneshot words after clear", int'(wrd[1]), 0);
`endif

    // Unlimited burst: 800 -> 256 without gaps; the final DRAIN cycle at 256 has no read.
    en[2] = 1'b1;
    srdy[2] = 1'b1;
    load(2, 800);
    found = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      if (drn[2]) begin
        found = 1'b1;
        break;
      end
    end
    chk("unl drain start", int'(found), 1);
    reads = 0; stalls = 0; bursts = 0; to = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      if (!drn[2]) begin
        to = 1'b0;
        break;
      end
      if (rd[2]) reads++;
      else stalls++;
      if (bdone[2]) bursts++;
      @(negedge clk); #1;
    end
    chk("unl timeout", int'(to), 0);
    chk("unl reads", reads, 544);
    chk("unl burst_done pulses", bursts, 0);
    chk("unl non-read cycles", stalls, 1);
    chk("unl final usedw", lvl[2], 256);
`ifdef DRAIN_STATS_EN
    chk("unl words_read", int'(wrd[2]), 544);
    chk("unl drain_events", int'(dev[2]), 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
